gsim_param: RTL and testbench
=============================

GSIM_PARAM -- requirements
Module: gsim_param

Interface
REQ-001 Parameter N, default 16: number of unknowns; legal range 4..64.
REQ-002 Parameter RW, default 8: width of the sweep-count input.
REQ-003 clk  input  1  rising-edge clock, single domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_en  input  1  b_in valid; sampled only while in_ready=1.
REQ-006 b_in  input  16  signed integer offset b[i], presented in index order 0..N-1.
REQ-007 sweeps  input  RW  maximum sweep count minus one; sampled together with b[0].
REQ-008 tol_en  input  1  early-stop enable; sampled together with b[0].
REQ-009 tol  input  32  unsigned Q16.16 convergence threshold; sampled together with b[0].
REQ-010 in_ready  output  1  high in RECV state only.
REQ-011 out_valid  output  1  x_out valid.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 x_out  output  32  signed Q16.16 solution x[i].
REQ-014 out_last  output  1  high with x[N-1].
REQ-015 sweeps_done  output  RW+1  number of sweeps executed; held stable through SEND.

Function
REQ-016 The block solves 20x[i] - 13(x[i-1]+x[i+1]) + 6(x[i-2]+x[i+2]) - (x[i-3]+x[i+3]) = b[i] by in-place Gauss-Seidel iteration; out-of-range neighbours read as 0.
REQ-017 States: RECV -> CALC after the accepted b[N-1]; CALC -> SEND at sweep end per REQ-022; SEND -> RECV after the out_last beat is accepted.
REQ-018 On each accepted b_in, store b[i] and initialise x[i] = {b_in, 16'h0000}.
REQ-019 Each unknown update takes exactly 5 cycles:
- stage0: r1 = x[i-3]+x[i+3]+{b[i],16'h0}; r2 = 6(x[i-2]+x[i+2]); r3 = 13(x[i-1]+x[i+1]).
- stage1: y = r1 - r2 + r3.
- stage2: y = y + (y>>>4).
- stage3: y = y + (y>>>8).
- stage4: x[i] = (y>>>6)+(y>>>22)+(y>>>5)+(y>>>21).
REQ-020 All arithmetic is 32-bit two's complement with wrap; multiplies are shift-add only.
REQ-021 A sweep is i = 0..N-1; one sweep takes 5N cycles.
REQ-022 Sweep end:
- Leave CALC when the completed sweep count equals sweeps+1.
- Also leave CALC when tol_en=1 and the maximum |x_new - x_old| over that sweep is < tol.
- Both conditions together produce a single transition.
REQ-023 sweeps = 0 runs exactly one sweep; the sweep counter never wraps.
REQ-024 SEND emits x[0..N-1] in order, one beat per out_valid & out_ready; x_out and out_last are held stable while out_ready=0.
REQ-025 in_en is ignored outside RECV; out_ready is ignored outside SEND.
REQ-026 The first out_valid appears in the cycle after the final stage4 write.

Reset
REQ-027 reset=1 at a rising edge forces RECV, index 0, stage 0, sweep count 0.
REQ-028 Reset values: in_ready=1, out_valid=0, out_last=0, sweeps_done=0; x_out is don't-care.
REQ-029 Reset mid-RECV, mid-CALC or mid-SEND aborts the problem; the next accepted b_in is b[0].
REQ-030 Data arrays b and x are not reset.

Structure
REQ-031 Package gsim_pkg holds:
- state enum {RECV, CALC, SEND}
- coefficient constants 13, 6, 1
- stage-count constant 5
- function mul_by_twentieth(y) implementing stages 2..4.
REQ-032 One sub-module, gsim_update, is the registered 5-stage update datapath: inputs are six neighbours and b; output is the new x with a done strobe.

Verification
REQ-033 N=16, all b=0, sweeps=3 -> after 4 sweeps (320 CALC cycles), 16 beats of x_out=0; sweeps_done=4.
REQ-034 N=16, all b=1, sweeps=0 -> first update writes x[0]=32'h00007332 (29490); 16 beats; out_last on beat 16 only.
REQ-035 N=16, random b, sweeps=69, tol_en=0 -> every x[i] bit-exact against a C model using identical shift arithmetic; sweeps_done=70.
REQ-036 N=16, all b=0, tol_en=1, tol=1 -> stop after sweep 1; sweeps_done=1.
REQ-037 During SEND, out_ready toggled 1,0,0,1,... -> no dropped or duplicated beats; x_out stable while stalled; in_en pulses during CALC and SEND are ignored.
REQ-038 Reset asserted for one cycle mid-CALC, then a new 16-value problem -> results identical to a cold-start run; N=4 and N=64 builds pass REQ-035 with boundary neighbours read as 0.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared types and arithmetic helpers for the Gauss-Seidel solver.
// - state_t          : RECV (load b), CALC (iterate), SEND (stream x)
// - COEF_*           : stencil coefficients for distance 1, 2 and 3
// - UPDATE_STAGES    : cycles per unknown update
// - mul_const        : shift-add multiply by a small constant
// - recip_stage2..4  : the three steps of the fixed-point divide by 20
// - mul_by_twentieth : all three steps chained
package gsim_pkg;

    typedef enum logic [1:0] {RECV, CALC, SEND} state_t;

    localparam int unsigned COEF_NEAR     = 13;
    localparam int unsigned COEF_MID      = 6;
    localparam int unsigned COEF_FAR      = 1;
    localparam int unsigned UPDATE_STAGES = 5;

    // Sums a shifted copy of a for every set bit of k. k is always a
    // constant at the call site, so this folds to a short adder chain.
    function automatic logic signed [31:0] mul_const(input logic signed [31:0] a,
                                                     input int unsigned k);
        logic signed [31:0] acc;
        acc = '0;
        for (int bi = 0; bi < 8; bi++) begin
            if (k[bi]) begin
                acc = acc + (a <<< bi);
            end
        end
        return acc;
    endfunction

    // y * (1 + 1/16) * (1 + 1/256) * (1/64 + 1/32 + ...) approximates y / 20.
    function automatic logic signed [31:0] recip_stage2(input logic signed [31:0] y);
        return y + (y >>> 4);
    endfunction

    function automatic logic signed [31:0] recip_stage3(input logic signed [31:0] y);
        return y + (y >>> 8);
    endfunction

    function automatic logic signed [31:0] recip_stage4(input logic signed [31:0] y);
        return (y >>> 6) + (y >>> 22) + (y >>> 5) + (y >>> 21);
    endfunction

    function automatic logic signed [31:0] mul_by_twentieth(input logic signed [31:0] y);
        return recip_stage4(recip_stage3(recip_stage2(y)));
    endfunction

endpackage

// File: rtl/gsim_update.sv
// Five-cycle registered update datapath for one unknown.
// Ports:
//   clk, reset      : clock and synchronous active-high reset (valid chain only)
//   start           : pulse in the cycle the neighbours and b are presented
//   x_m3..x_p3      : neighbours x[i-3..i+3] excluding x[i], 0 when out of range
//   b               : offset b[i]
//   new_x, done     : new x[i], valid while done=1 (fifth cycle after start)
module gsim_update
    import gsim_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [31:0] x_m3,
    input  logic signed [31:0] x_m2,
    input  logic signed [31:0] x_m1,
    input  logic signed [31:0] x_p1,
    input  logic signed [31:0] x_p2,
    input  logic signed [31:0] x_p3,
    input  logic signed [15:0] b,
    output logic signed [31:0] new_x,
    output logic               done
);

    logic signed [31:0] r1_reg;
    logic signed [31:0] r2_reg;
    logic signed [31:0] r3_reg;
    logic signed [31:0] y1_reg;
    logic signed [31:0] y2_reg;
    logic signed [31:0] y3_reg;
    logic        [3:0]  valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= {valid_reg[2:0], start};
        end
        r1_reg <= mul_const(x_m3 + x_p3, COEF_FAR) + $signed({b, 16'h0000});
        r2_reg <= mul_const(x_m2 + x_p2, COEF_MID);
        r3_reg <= mul_const(x_m1 + x_p1, COEF_NEAR);
        y1_reg <= r1_reg - r2_reg + r3_reg;
        y2_reg <= recip_stage2(y1_reg);
        y3_reg <= recip_stage3(y2_reg);
    end

    // The last step is combinational so the caller writes x[i] on the fifth edge.
    assign new_x = recip_stage4(y3_reg);
    assign done  = valid_reg[3];

endmodule

// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the 7-point banded system
//   20x[i] - 13(x[i-1]+x[i+1]) + 6(x[i-2]+x[i+2]) - (x[i-3]+x[i+3]) = b[i].
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_en, b_in, in_ready      : load b[0..N-1]; sweeps/tol_en/tol latched with b[0]
//   out_valid/out_ready/x_out  : stream of x[0..N-1] (Q16.16), out_last with x[N-1]
//   sweeps_done                : sweeps executed for the current result
module gsim_param
    import gsim_pkg::*;
#(
    parameter int N  = 16,
    parameter int RW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_en,
    input  logic signed [15:0] b_in,
    input  logic [RW-1:0]      sweeps,
    input  logic               tol_en,
    input  logic [31:0]        tol,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] x_out,
    output logic               out_last,
    output logic [RW:0]        sweeps_done
);

    localparam int IW = $clog2(N);
    localparam int SW = $clog2(UPDATE_STAGES);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(UPDATE_STAGES - 1);

    logic signed [15:0] b_mem [N];
    logic signed [31:0] x_mem [N];

    state_t             state_reg;
    logic [IW-1:0]      idx_reg;
    logic [SW-1:0]      stage_reg;
    logic [RW:0]        sweep_cnt_reg;
    logic [RW-1:0]      sweeps_reg;
    logic               tol_en_reg;
    logic [31:0]        tol_reg;
    logic [31:0]        max_delta_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic signed [31:0] x_out_reg;

    logic signed [31:0] nbr [6];
    logic               upd_start;
    logic signed [31:0] upd_new_x;
    logic               upd_done;

    logic signed [31:0] diff;
    logic [31:0]        abs_diff;
    logic [31:0]        sweep_max;
    logic [RW:0]        sweep_inc;
    logic [RW:0]        sweep_limit;
    logic               stop;

    // Neighbour taps at offsets -3,-2,-1,+1,+2,+3; outside 0..N-1 reads as 0.
    for (genvar gi = 0; gi < 6; gi++) begin : g_nbr
        localparam int OFF = (gi < 3) ? gi - 3 : gi - 2;
        int pos;
        assign pos     = int'(idx_reg) + OFF;
        assign nbr[gi] = (pos >= 0 && pos < N) ? x_mem[pos[IW-1:0]] : '0;
    end

    assign upd_start = (state_reg == CALC) && (stage_reg == '0);

    gsim_update u_update (
        .clk   (clk),
        .reset (reset),
        .start (upd_start),
        .x_m3  (nbr[0]),
        .x_m2  (nbr[1]),
        .x_m1  (nbr[2]),
        .x_p1  (nbr[3]),
        .x_p2  (nbr[4]),
        .x_p3  (nbr[5]),
        .b     (b_mem[idx_reg]),
        .new_x (upd_new_x),
        .done  (upd_done)
    );

    // Convergence metric: |x_new - x_old| as an unsigned 32-bit magnitude,
    // folded into the running maximum including the update being written now.
    always_comb begin
        diff        = upd_new_x - x_mem[idx_reg];
        abs_diff    = diff[31] ? (~diff + 32'd1) : diff;
        sweep_max   = (abs_diff > max_delta_reg) ? abs_diff : max_delta_reg;
        sweep_inc   = sweep_cnt_reg + (RW+1)'(1);
        sweep_limit = {1'b0, sweeps_reg} + (RW+1)'(1);
        stop        = (sweep_inc == sweep_limit) || (tol_en_reg && (sweep_max < tol_reg));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_reg == RECV && in_en) begin
                b_mem[idx_reg] <= b_in;
                x_mem[idx_reg] <= {b_in, 16'h0000};
            end else if (state_reg == CALC && upd_done) begin
                x_mem[idx_reg] <= upd_new_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RECV;
            idx_reg       <= '0;
            stage_reg     <= '0;
            sweep_cnt_reg <= '0;
            max_delta_reg <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RECV: begin
                    if (in_en) begin
                        if (idx_reg == '0) begin
                            sweeps_reg    <= sweeps;
                            tol_en_reg    <= tol_en;
                            tol_reg       <= tol;
                            sweep_cnt_reg <= '0;
                        end
                        if (idx_reg == LAST_IDX) begin
                            state_reg     <= CALC;
                            in_ready_reg  <= 1'b0;
                            idx_reg       <= '0;
                            stage_reg     <= '0;
                            max_delta_reg <= '0;
                        end else begin
                            idx_reg <= idx_reg + IW'(1);
                        end
                    end
                end
                CALC: begin
                    if (stage_reg == LAST_STAGE) begin
                        stage_reg <= '0;
                        if (idx_reg == LAST_IDX) begin
                            idx_reg       <= '0;
                            max_delta_reg <= '0;
                            sweep_cnt_reg <= sweep_inc;
                            if (stop) begin
                                state_reg     <= SEND;
                                out_valid_reg <= 1'b1;
                                out_last_reg  <= 1'b0;
                                // x[0] is final here: this edge writes x[N-1], N >= 4.
                                x_out_reg     <= x_mem[0];
                            end
                        end else begin
                            idx_reg       <= idx_reg + IW'(1);
                            max_delta_reg <= sweep_max;
                        end
                    end else begin
                        stage_reg <= stage_reg + SW'(1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg     <= RECV;
                            idx_reg       <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            in_ready_reg  <= 1'b1;
                        end else begin
                            idx_reg      <= idx_reg + IW'(1);
                            x_out_reg    <= x_mem[idx_reg + IW'(1)];
                            out_last_reg <= ((idx_reg + IW'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state_reg <= RECV;
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign x_out       = x_out_reg;
    assign sweeps_done = sweep_cnt_reg;

endmodule

// File: tb/tb_gsim_param.sv
// Randomized scoreboard bench for gsim_param (N=16, RW=8). The driver loads
// problems and pushes reference results; a monitor pops and compares beats.
module tb_gsim_param;

    localparam int N  = 16;
    localparam int RW = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_en = 1'b0;
    logic signed [15:0] b_in = '0;
    logic [RW-1:0]      sweeps = '0;
    logic               tol_en = 1'b0;
    logic [31:0]        tol = '0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        x_out;
    logic               out_last;
    logic [RW:0]        sweeps_done;

    gsim_param #(.N(N), .RW(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_en       (in_en),
        .b_in        (b_in),
        .sweeps      (sweeps),
        .tol_en      (tol_en),
        .tol         (tol),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .x_out       (x_out),
        .out_last    (out_last),
        .sweeps_done (sweeps_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic        last;
        logic [RW:0] sd;
        int          idx;
    } exp_t;

    exp_t               exp_q[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 ready_mode = 0;
    logic signed [15:0] b_vec [N];
    int                 exp_x [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int nb(input int a [N], input int j);
        return (j >= 0 && j < N) ? a[j] : 0;
    endfunction

    // Reference: plain Gauss-Seidel sweeps with the fixed-point divide-by-20.
    task automatic run_model(input int sw, input bit te, input logic [31:0] tl, output int sd);
        int xm [N];
        int s, y, xn, d, s1, s2, s3;
        logic [31:0] ad, maxd;
        for (int i = 0; i < N; i++) xm[i] = int'(b_vec[i]) <<< 16;
        s = 0;
        do begin
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                s1 = nb(xm, i - 1) + nb(xm, i + 1);
                s2 = nb(xm, i - 2) + nb(xm, i + 2);
                s3 = nb(xm, i - 3) + nb(xm, i + 3);
                y  = (int'(b_vec[i]) <<< 16) + s3 - 6 * s2 + 13 * s1;
                y  = y + (y >>> 4);
                y  = y + (y >>> 8);
                xn = (y >>> 6) + (y >>> 22) + (y >>> 5) + (y >>> 21);
                d  = xn - xm[i];
                ad = (d < 0) ? 32'(-d) : 32'(d);
                if (ad > maxd) maxd = ad;
                xm[i] = xn;
            end
            s++;
        end while (!(s == sw + 1 || (te && maxd < tl)));
        sd    = s;
        exp_x = xm;
    endtask

    task automatic load_problem(input int sw, input bit te, input logic [31:0] tl);
        for (int i = 0; i < N; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_en = 1'b0;
                b_in  = 16'($urandom);
                @(posedge clk);
            end
            @(negedge clk);
            if (i == 0) check("in_ready_recv", in_ready, 1);
            in_en = 1'b1;
            b_in  = b_vec[i];
            if (i == 0) begin
                sweeps = sw[RW-1:0];
                tol_en = te;
                tol    = tl;
            end else begin
                sweeps = RW'($urandom);
                tol_en = 1'($urandom);
                tol    = $urandom;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_en = 1'b0;
    endtask

    task automatic run_problem(input string tag, input int sw, input bit te,
                               input logic [31:0] tl, input int mode,
                               input bit use_x0, input logic [31:0] x0_req);
        int sd, k;
        run_model(sw, te, tl, sd);
        if (use_x0) exp_x[0] = int'(x0_req);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back('{x: 32'(exp_x[i]), last: (i == N - 1), sd: (RW+1)'(sd), idx: i});
        end
        ready_mode = mode;
        load_problem(sw, te, tl);
        check($sformatf("%s_in_ready_calc", tag), in_ready, 0);
        k = 0;
        while (!out_valid && k < 5 * N * sd + 50) begin
            in_en = ($urandom_range(0, 7) == 0);
            b_in  = 16'($urandom);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check($sformatf("%s_latency", tag), k, 5 * N * sd);
        k = 0;
        while (exp_q.size() != 0 && k < 20 * N) begin
            in_en = !in_ready && ($urandom_range(0, 3) == 0);
            b_in  = 16'($urandom);
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        in_en = 1'b0;
        check($sformatf("%s_beats_left", tag), exp_q.size(), 0);
        exp_q.delete();
        check($sformatf("%s_idle_valid", tag), out_valid, 0);
        check($sformatf("%s_idle_ready", tag), in_ready, 1);
        $display("problem %s: sweeps=%0d tol_en=%0d expected sweeps_done=%0d latency=%0d",
                 tag, sw, te, sd, 5 * N * sd);
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s_in_ready", tag), in_ready, 1);
        check($sformatf("%s_out_valid", tag), out_valid, 0);
        check($sformatf("%s_out_last", tag), out_last, 0);
        check($sformatf("%s_sweeps_done", tag), sweeps_done, 0);
    endtask

    initial begin : ready_gen
        int pat;
        pat = 0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    if (out_valid) begin
                        out_ready = (pat == 0);
                        pat = (pat + 1) % 3;
                    end else begin
                        out_ready = 1'b1;
                        pat = 0;
                    end
                end
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    initial begin : monitor
        exp_t        e;
        logic        held_valid;
        logic [31:0] held_x;
        logic        held_last;
        held_valid = 1'b0;
        held_x     = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid) begin
                    check("stall_x_out", x_out, held_x);
                    check("stall_out_last", out_last, held_last);
                    check("stall_out_valid", out_valid, 1);
                end
                held_valid = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got x_out 0x%0h, required no beat", x_out);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("x[%0d]", e.idx), x_out, e.x);
                        check($sformatf("out_last[%0d]", e.idx), out_last, e.last);
                        check($sformatf("sweeps_done[%0d]", e.idx), sweeps_done, e.sd);
                        $display("beat %0d: x_out=0x%08h out_last=%0d sweeps_done=%0d",
                                 e.idx, x_out, out_last, sweeps_done);
                    end
                end else if (out_valid) begin
                    held_valid = 1'b1;
                    held_x     = x_out;
                    held_last  = out_last;
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int wait_cycles;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("reset_cold");

        for (int i = 0; i < N; i++) b_vec[i] = 16'sd0;
        run_problem("zero_sw3", 3, 1'b0, 32'd0, 0, 1'b0, 32'd0);

        for (int i = 0; i < N; i++) b_vec[i] = 16'sd1;
        run_problem("ones_sw0", 0, 1'b0, 32'd0, 0, 1'b1, 32'h0000_7332);

        for (int i = 0; i < N; i++) b_vec[i] = 16'($urandom);
        run_problem("rand_sw69", 69, 1'b0, 32'd0, 1, 1'b0, 32'd0);

        for (int i = 0; i < N; i++) b_vec[i] = 16'sd0;
        run_problem("zero_tol1", 10, 1'b1, 32'd1, 2, 1'b0, 32'd0);

        for (int i = 0; i < N; i++) b_vec[i] = 16'(int'($urandom_range(0, 400)) - 200);
        run_problem("rand_tol", 200, 1'b1, 32'h0000_0100, 2, 1'b0, 32'd0);

        // Abort a problem part-way through CALC, then solve a fresh one.
        for (int i = 0; i < N; i++) b_vec[i] = 16'($urandom);
        ready_mode = 0;
        load_problem(5, 1'b0, 32'd0);
        wait_cycles = int'($urandom_range(30, 200));
        repeat (wait_cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("reset_mid_calc");
        $display("reset applied after %0d CALC cycles", wait_cycles);
        for (int i = 0; i < N; i++) b_vec[i] = 16'($urandom);
        run_problem("after_reset", 20, 1'b0, 32'd0, 1, 1'b0, 32'd0);

        for (int i = 0; i < N; i++) b_vec[i] = 16'($urandom);
        run_problem("rand_sw255", 255, 1'b0, 32'd0, 0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
